// File: rtl/lcd_drive_pkg.sv
// lcd_drive_pkg
//   Shared constants for the LCD drive AHB register block: field widths,
//   register byte offsets, AHB encodings, STATUS bit positions and the
//   legal-transfer check used by the AHB slave front end.
package lcd_drive_pkg;

  localparam int LCD_W_ADDR       = 32;
  localparam int LCD_W_DATA       = 32;
  localparam int LCD_W_SIZE       = 12;
  localparam int LCD_W_DELAY      = 12;
  localparam int LCD_W_FRAME_SIZE = 2 * LCD_W_SIZE + 1;
  localparam int LCD_IMG_PIX_W    = 8;

  localparam logic [11:0] LCD_DRIVE_WIDTH_OFS             = 12'h000;
  localparam logic [11:0] LCD_DRIVE_HEIGHT_OFS            = 12'h004;
  localparam logic [11:0] LCD_DRIVE_START_UP_DELAY_OFS    = 12'h008;
  localparam logic [11:0] LCD_DRIVE_VSYNC_CYCLE_OFS       = 12'h00C;
  localparam logic [11:0] LCD_DRIVE_VSYNC_DELAY_OFS       = 12'h010;
  localparam logic [11:0] LCD_DRIVE_HSYNC_DELAY_OFS       = 12'h014;
  localparam logic [11:0] LCD_DRIVE_FRAME_TRANS_DELAY_OFS = 12'h018;
  localparam logic [11:0] LCD_DRIVE_DATA_COUNT_OFS        = 12'h01C;
  localparam logic [11:0] LCD_DRIVE_BR_MODE_OFS           = 12'h020;
  localparam logic [11:0] LCD_DRIVE_BR_VALUE_OFS          = 12'h024;
  localparam logic [11:0] LCD_DRIVE_START_OFS             = 12'h028;
  localparam logic [11:0] LCD_DRIVE_STATUS_OFS            = 12'h02C;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam int STATUS_BUSY_BIT       = 0;
  localparam int STATUS_FRAME_DONE_BIT = 1;
  localparam int STATUS_OVERRUN_BIT    = 2;

  // Only aligned word accesses inside the register window are accepted.
  function automatic logic legal_xfer(input logic [2:0] hsize, input logic [11:0] addr);
    return (hsize == HSIZE_WORD) && (addr[1:0] == 2'b00) && (addr <= LCD_DRIVE_STATUS_OFS);
  endfunction

endpackage

// File: rtl/lcd_drive_ahb_regs_if.sv
// lcd_drive_ahb_regs_if
//   AHB-Lite signal bundle between the fabric (master modport) and the LCD
//   drive register block (slave modport).
//   HSEL/HADDR/HTRANS/HWRITE/HSIZE/HWDATA/HREADY : master -> slave
//   HREADYOUT/HRESP/HRDATA                        : slave -> master
interface lcd_drive_ahb_regs_if #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32
);
  logic              HSEL;
  logic [W_ADDR-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [W_DATA-1:0] HWDATA;
  logic              HREADY;
  logic              HREADYOUT;
  logic              HRESP;
  logic [W_DATA-1:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRESP
  `ifdef LCD_DRIVE_NEVER_DEFINED
  `endif
    , output HRDATA
  );
endinterface

// File: rtl/lcd_drive_ahb_regs_ahb_slave_if.sv
// ahb_slave_if
//   AHB-Lite front end: captures the address phase and runs the OKAY/ERROR
//   response FSM. Hands the register bank a one-cycle wr_en or rd_en during
//   a legal data phase, with the latched offset and the live HWDATA.
//   Ports: HCLK, HRESETn (async active-low), ahb (slave modport; drives
//   HREADYOUT and HRESP), wr_en, rd_en, offset[11:0], wdata.
//
//   state | meaning
//   IDLE  | no data phase pending
//   DATA  | legal data phase, zero wait
//   ERR1  | error cycle 1: HREADYOUT=0, HRESP=1
//   ERR2  | error cycle 2: HREADYOUT=1, HRESP=1
module ahb_slave_if
  import lcd_drive_pkg::*;
#(
  parameter int W_ADDR = LCD_W_ADDR,
  parameter int W_DATA = LCD_W_DATA
)(
  input  logic              HCLK,
  input  logic              HRESETn,
  lcd_drive_ahb_regs_if.slave ahb,
  output logic              wr_en,
  output logic              rd_en,
  output logic [11:0]       offset,
  output logic [W_DATA-1:0] wdata
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_ERR1 = 2'd2;
  localparam logic [1:0] ST_ERR2 = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [11:0] ofs_q;
  logic        write_q;
  logic        addr_phase;
  logic        legal;

  assign addr_phase = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
  assign legal      = legal_xfer(ahb.HSIZE, ahb.HADDR[11:0]);

  // ERR1 always proceeds to ERR2; any address phase seen there is ignored
  // because the bus is stalled by our own HREADYOUT=0.
  always_comb begin
    state_d = ST_IDLE;
    if (state_q == ST_ERR1) begin
      state_d = ST_ERR2;
    end else if (addr_phase) begin
      state_d = legal ? ST_DATA : ST_ERR1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      ofs_q   <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q != ST_ERR1 && addr_phase && legal) begin
        ofs_q   <= ahb.HADDR[11:0];
        write_q <= ahb.HWRITE;
      end
    end
  end

  assign ahb.HREADYOUT = (state_q != ST_ERR1);
  assign ahb.HRESP     = (state_q == ST_ERR1 || state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;

  assign wr_en  = (state_q == ST_DATA) &  write_q;
  assign rd_en  = (state_q == ST_DATA) & ~write_q;
  assign offset = ofs_q;
  assign wdata  = ahb.HWDATA;

  logic unused_addr;
  assign unused_addr = ^ahb.HADDR[W_ADDR-1:12];

endmodule

// File: rtl/lcd_drive_ahb_regs.sv
// lcd_drive_ahb_regs
//   LCD drive configuration/control register block on AHB-Lite.
//   Ports: HCLK, HRESETn (async active-low), ahb (slave modport),
//   drv_busy / drv_frame_done (engine status in), cfg_* (static
//   configuration out), drv_start (one-cycle start pulse out).
//   Build option LCD_REGS_SHADOW_EN: cfg_* come from shadow copies taken on
//   each drv_start pulse, so configuration is frozen during a frame.
module lcd_drive_ahb_regs
  import lcd_drive_pkg::*;
#(
  parameter int W_ADDR       = LCD_W_ADDR,
  parameter int W_DATA       = LCD_W_DATA,
  parameter int W_SIZE       = LCD_W_SIZE,
  parameter int W_DELAY      = LCD_W_DELAY,
  parameter int W_FRAME_SIZE = LCD_W_FRAME_SIZE,
  parameter int IMG_PIX_W    = LCD_IMG_PIX_W
)(
  input  logic                    HCLK,
  input  logic                    HRESETn,
  lcd_drive_ahb_regs_if.slave     ahb,
  input  logic                    drv_busy,
  input  logic                    drv_frame_done,
  output logic [W_SIZE-1:0]       cfg_width,
  output logic [W_SIZE-1:0]       cfg_height,
  output logic [W_DELAY-1:0]      cfg_start_up_delay,
  output logic [W_DELAY-1:0]      cfg_vsync_cycle,
  output logic [W_DELAY-1:0]      cfg_vsync_delay,
  output logic [W_DELAY-1:0]      cfg_hsync_delay,
  output logic [W_DELAY-1:0]      cfg_frame_trans_delay,
  output logic [W_FRAME_SIZE-1:0] cfg_data_count,
  output logic                    cfg_br_mode,
  output logic [IMG_PIX_W-1:0]    cfg_br_value,
  output logic                    drv_start
);

  localparam int CFG_W = 2*W_SIZE + 5*W_DELAY + W_FRAME_SIZE + 1 + IMG_PIX_W;

  logic              wr_en, rd_en;
  logic [11:0]       offset;
  logic [W_DATA-1:0] wdata;

  ahb_slave_if #(.W_ADDR(W_ADDR), .W_DATA(W_DATA)) u_ahb_slave_if (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .ahb     (ahb),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .offset  (offset),
    .wdata   (wdata)
  );

  logic [W_SIZE-1:0]       width_q, height_q;
  logic [W_DELAY-1:0]      start_up_delay_q, vsync_cycle_q, vsync_delay_q;
  logic [W_DELAY-1:0]      hsync_delay_q, frame_trans_delay_q;
  logic [W_FRAME_SIZE-1:0] data_count_q;
  logic                    br_mode_q;
  logic [IMG_PIX_W-1:0]    br_value_q;
  logic                    frame_done_q, overrun_q;
  logic                    start_req, status_wr;

  assign start_req = wr_en && (offset == LCD_DRIVE_START_OFS) && wdata[0];
  assign status_wr = wr_en && (offset == LCD_DRIVE_STATUS_OFS);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      width_q             <= '0;
      height_q            <= '0;
      start_up_delay_q    <= '0;
      vsync_cycle_q       <= '0;
      vsync_delay_q       <= '0;
      hsync_delay_q       <= '0;
      frame_trans_delay_q <= '0;
      data_count_q        <= '0;
      br_mode_q           <= 1'b0;
      br_value_q          <= '0;
      frame_done_q        <= 1'b0;
      overrun_q           <= 1'b0;
      drv_start           <= 1'b0;
    end else begin
      drv_start <= start_req & ~drv_busy;
      // Sticky bits: a set in the same cycle as the W1C takes priority.
      frame_done_q <= drv_frame_done |
                      (frame_done_q & ~(status_wr & wdata[STATUS_FRAME_DONE_BIT]));
      overrun_q    <= (start_req & drv_busy) |
                      (overrun_q & ~(status_wr & wdata[STATUS_OVERRUN_BIT]));
      if (wr_en) begin
        case (offset)
          LCD_DRIVE_WIDTH_OFS:             width_q             <= wdata[W_SIZE-1:0];
          LCD_DRIVE_HEIGHT_OFS:            height_q            <= wdata[W_SIZE-1:0];
          LCD_DRIVE_START_UP_DELAY_OFS:    start_up_delay_q    <= wdata[W_DELAY-1:0];
          LCD_DRIVE_VSYNC_CYCLE_OFS:       vsync_cycle_q       <= wdata[W_DELAY-1:0];
          LCD_DRIVE_VSYNC_DELAY_OFS:       vsync_delay_q       <= wdata[W_DELAY-1:0];
          LCD_DRIVE_HSYNC_DELAY_OFS:       hsync_delay_q       <= wdata[W_DELAY-1:0];
          LCD_DRIVE_FRAME_TRANS_DELAY_OFS: frame_trans_delay_q <= wdata[W_DELAY-1:0];
          LCD_DRIVE_DATA_COUNT_OFS:        data_count_q        <= wdata[W_FRAME_SIZE-1:0];
          LCD_DRIVE_BR_MODE_OFS:           br_mode_q           <= wdata[0];
          LCD_DRIVE_BR_VALUE_OFS:          br_value_q          <= wdata[IMG_PIX_W-1:0];
          default: ;
        endcase
      end
    end
  end

  logic [W_DATA-1:0] rd_word;

  always_comb begin
    rd_word = '0;
    case (offset)
      LCD_DRIVE_WIDTH_OFS:             rd_word = W_DATA'(width_q);
      LCD_DRIVE_HEIGHT_OFS:            rd_word = W_DATA'(height_q);
      LCD_DRIVE_START_UP_DELAY_OFS:    rd_word = W_DATA'(start_up_delay_q);
      LCD_DRIVE_VSYNC_CYCLE_OFS:       rd_word = W_DATA'(vsync_cycle_q);
      LCD_DRIVE_VSYNC_DELAY_OFS:       rd_word = W_DATA'(vsync_delay_q);
      LCD_DRIVE_HSYNC_DELAY_OFS:       rd_word = W_DATA'(hsync_delay_q);
      LCD_DRIVE_FRAME_TRANS_DELAY_OFS: rd_word = W_DATA'(frame_trans_delay_q);
      LCD_DRIVE_DATA_COUNT_OFS:        rd_word = W_DATA'(data_count_q);
      LCD_DRIVE_BR_MODE_OFS:           rd_word = W_DATA'(br_mode_q);
      LCD_DRIVE_BR_VALUE_OFS:          rd_word = W_DATA'(br_value_q);
      LCD_DRIVE_STATUS_OFS: begin
        rd_word[STATUS_BUSY_BIT]       = drv_busy;
        rd_word[STATUS_FRAME_DONE_BIT] = frame_done_q;
        rd_word[STATUS_OVERRUN_BIT]    = overrun_q;
      end
      default: rd_word = '0;
    endcase
  end

  assign ahb.HRDATA = rd_en ? rd_word : '0;

  logic [CFG_W-1:0] cfg_prog, cfg_live;

  assign cfg_prog = {width_q, height_q, start_up_delay_q, vsync_cycle_q, vsync_delay_q,
                     hsync_delay_q, frame_trans_delay_q, data_count_q, br_mode_q, br_value_q};

`ifdef LCD_REGS_SHADOW_EN
  logic [CFG_W-1:0] cfg_shadow_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cfg_shadow_q <= '0;
    end else if (drv_start) begin
      cfg_shadow_q <= cfg_prog;
    end
  end

  assign cfg_live = cfg_shadow_q;
`else
  assign cfg_live = cfg_prog;
`endif

  assign {cfg_width, cfg_height, cfg_start_up_delay, cfg_vsync_cycle, cfg_vsync_delay,
          cfg_hsync_delay, cfg_frame_trans_delay, cfg_data_count, cfg_br_mode,
          cfg_br_value} = cfg_live;

  logic unused_wdata;
  assign unused_wdata = ^wdata[W_DATA-1:W_FRAME_SIZE];

endmodule

// File: tb/tb_lcd_drive_ahb_regs.sv
// tb_lcd_drive_ahb_regs
//   Directed bench for lcd_drive_ahb_regs. Bus transfers push their expected
//   response into a queue; a negedge monitor pops and compares whenever a
//   data phase completes. Sideband outputs are checked from the stimulus.
module tb_lcd_drive_ahb_regs;
  import lcd_drive_pkg::*;

`ifdef LCD_REGS_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b1;
  logic        drv_busy = 1'b0;
  logic        drv_frame_done = 1'b0;
  logic [11:0] cfg_width, cfg_height;
  logic [11:0] cfg_start_up_delay, cfg_vsync_cycle, cfg_vsync_delay;
  logic [11:0] cfg_hsync_delay, cfg_frame_trans_delay;
  logic [24:0] cfg_data_count;
  logic        cfg_br_mode;
  logic [7:0]  cfg_br_value;
  logic        drv_start;

  lcd_drive_ahb_regs_if #(.W_ADDR(32), .W_DATA(32)) bus ();
  assign bus.HREADY = bus.HREADYOUT;

  always #5 HCLK = ~HCLK;

  lcd_drive_ahb_regs dut (
    .HCLK                  (HCLK),
    .HRESETn               (HRESETn),
    .ahb                   (bus),
    .drv_busy              (drv_busy),
    .drv_frame_done        (drv_frame_done),
    .cfg_width             (cfg_width),
    .cfg_height            (cfg_height),
    .cfg_start_up_delay    (cfg_start_up_delay),
    .cfg_vsync_cycle       (cfg_vsync_cycle),
    .cfg_vsync_delay       (cfg_vsync_delay),
    .cfg_hsync_delay       (cfg_hsync_delay),
    .cfg_frame_trans_delay (cfg_frame_trans_delay),
    .cfg_data_count        (cfg_data_count),
    .cfg_br_mode           (cfg_br_mode),
    .cfg_br_value          (cfg_br_value),
    .drv_start             (drv_start)
  );

  typedef struct {
    logic        is_rd;
    logic [31:0] rd;
    int          waits;
    logic        resp;
    int          tag;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          start_cnt = 0;
  int          tag_n = 0;
  int          waits = 0;
  logic        dphase = 1'b0;
  logic [31:0] pend_wdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a data phase completes at the negedge where HREADYOUT is high.
  always @(negedge HCLK) begin
    exp_t e;
    if (drv_start) start_cnt++;
    if (!HRESETn) begin
      dphase = 1'b0;
      waits  = 0;
    end else begin
      if (dphase) begin
        if (!bus.HREADYOUT) begin
          waits++;
          check("resp_in_wait", 32'(bus.HRESP), 32'd1);
        end else if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_dphase: got a completed data phase, expected none");
        end else begin
          e = exp_q.pop_front();
          check($sformatf("hresp[%0d]", e.tag), 32'(bus.HRESP), 32'(e.resp));
          check($sformatf("waits[%0d]", e.tag), 32'(waits), 32'(e.waits));
          check($sformatf("hrdata[%0d]", e.tag), bus.HRDATA, e.is_rd ? e.rd : 32'd0);
          waits = 0;
        end
      end else begin
        check("hrdata_idle", bus.HRDATA, 32'd0);
      end
      if (bus.HREADYOUT) dphase = bus.HSEL & bus.HTRANS[1];
    end
  end

  task automatic wait_accept();
    int g = 0;
    @(negedge HCLK);
    while (!bus.HREADYOUT && g < 8) begin
      g++;
      @(negedge HCLK);
    end
    if (g >= 8) begin
      n_checks++;
      n_fail++;
      $display("FAIL hready_timeout: got HREADYOUT low for %0d cycles, expected at most 1", g);
    end
    @(posedge HCLK);
    #1;
  endtask

  task automatic op(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                    input logic [31:0] wd, input logic is_err, input logic [31:0] exp_rd,
                    input logic push);
    exp_t e;
    if (push) begin
      e.is_rd = !wr && !is_err;
      e.rd    = exp_rd;
      e.waits = is_err ? 1 : 0;
      e.resp  = is_err;
      e.tag   = tag_n;
      exp_q.push_back(e);
    end
    tag_n++;
    bus.HSEL   = 1'b1;
    bus.HADDR  = addr;
    bus.HTRANS = HTRANS_NONSEQ;
    bus.HWRITE = wr;
    bus.HSIZE  = size;
    bus.HWDATA = pend_wdata;
    wait_accept();
    pend_wdata = wd;
  endtask

  task automatic wr(input logic [11:0] ofs, input logic [31:0] d);
    op({20'h0, ofs}, 1'b1, HSIZE_WORD, d, 1'b0, 32'd0, 1'b1);
  endtask

  task automatic rd(input logic [11:0] ofs, input logic [31:0] exp);
    op({20'h0, ofs}, 1'b0, HSIZE_WORD, 32'd0, 1'b0, exp, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      bus.HSEL   = 1'b0;
      bus.HTRANS = HTRANS_IDLE;
      bus.HWRITE = 1'b0;
      bus.HWDATA = pend_wdata;
      wait_accept();
      pend_wdata = '0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    bus.HSEL = 1'b0; bus.HADDR = '0; bus.HTRANS = HTRANS_IDLE;
    bus.HWRITE = 1'b0; bus.HSIZE = HSIZE_WORD; bus.HWDATA = '0;
    #2 HRESETn = 1'b0;
    repeat (2) @(posedge HCLK);
    #1;
    check("rst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
    check("rst_hresp", 32'(bus.HRESP), 32'd0);
    check("rst_hrdata", bus.HRDATA, 32'd0);
    check("rst_drv_start", 32'(drv_start), 32'd0);
    check("rst_cfg_width", 32'(cfg_width), 32'd0);
    HRESETn = 1'b1;
    idle(1);

    // Geometry write/readback, back-to-back reads
    wr(LCD_DRIVE_WIDTH_OFS, 32'd768);
    wr(LCD_DRIVE_HEIGHT_OFS, 32'd512);
    rd(LCD_DRIVE_WIDTH_OFS, 32'h300);
    rd(LCD_DRIVE_HEIGHT_OFS, 32'h200);
    idle(1);
    check("cfg_width", 32'(cfg_width), SHADOW ? 32'd0 : 32'd768);
    check("cfg_height", 32'(cfg_height), SHADOW ? 32'd0 : 32'd512);

    // Field truncation
    wr(LCD_DRIVE_BR_VALUE_OFS, 32'hFFFF_FFFF);
    rd(LCD_DRIVE_BR_VALUE_OFS, 32'h0000_00FF);
    wr(LCD_DRIVE_DATA_COUNT_OFS, 32'hFFFF_FFFF);
    rd(LCD_DRIVE_DATA_COUNT_OFS, 32'h01FF_FFFF);
    wr(LCD_DRIVE_BR_MODE_OFS, 32'h3);
    rd(LCD_DRIVE_BR_MODE_OFS, 32'h1);
    wr(LCD_DRIVE_HSYNC_DELAY_OFS, 32'h0000_ABCD);
    rd(LCD_DRIVE_HSYNC_DELAY_OFS, 32'h0000_0BCD);
    idle(1);
    check("cfg_br_value", 32'(cfg_br_value), SHADOW ? 32'd0 : 32'hFF);
    check("cfg_data_count", 32'(cfg_data_count), SHADOW ? 32'd0 : 32'h01FF_FFFF);

    // Start pulse, idle engine
    s0 = start_cnt;
    wr(LCD_DRIVE_START_OFS, 32'h1);
    idle(3);
    check("start_pulse_len", 32'(start_cnt - s0), 32'd1);
    check("cfg_width_after_start", 32'(cfg_width), 32'd768);
    rd(LCD_DRIVE_START_OFS, 32'h0);
    rd(LCD_DRIVE_STATUS_OFS, 32'h0);

    // Writing 0 to START does nothing
    s0 = start_cnt;
    wr(LCD_DRIVE_START_OFS, 32'h0);
    idle(3);
    check("start_zero_pulse", 32'(start_cnt - s0), 32'd0);

    // Start while busy -> overrun, no pulse
    drv_busy = 1'b1;
    s0 = start_cnt;
    wr(LCD_DRIVE_START_OFS, 32'h1);
    idle(2);
    check("start_busy_pulse", 32'(start_cnt - s0), 32'd0);
    rd(LCD_DRIVE_STATUS_OFS, 32'h5);
    idle(1);
    drv_busy = 1'b0;
    wr(LCD_DRIVE_STATUS_OFS, 32'h4);
    rd(LCD_DRIVE_STATUS_OFS, 32'h0);
    idle(1);

    // frame_done set, set-wins-over-clear, clear alone
    drv_frame_done = 1'b1;
    @(posedge HCLK);
    #1;
    drv_frame_done = 1'b0;
    rd(LCD_DRIVE_STATUS_OFS, 32'h2);
    wr(LCD_DRIVE_STATUS_OFS, 32'h2);
    drv_frame_done = 1'b1;
    idle(1);
    drv_frame_done = 1'b0;
    rd(LCD_DRIVE_STATUS_OFS, 32'h2);
    wr(LCD_DRIVE_STATUS_OFS, 32'h2);
    rd(LCD_DRIVE_STATUS_OFS, 32'h0);
    idle(1);

    // Error transfers leave registers alone
    op(32'h0000_0030, 1'b0, HSIZE_WORD, 32'd0, 1'b1, 32'd0, 1'b1);
    idle(1);
    op(32'h0000_0000, 1'b1, 3'b001, 32'h0000_0ABC, 1'b1, 32'd0, 1'b1);
    idle(1);
    op(32'h0000_0006, 1'b0, HSIZE_WORD, 32'd0, 1'b1, 32'd0, 1'b1);
    idle(1);
    rd(LCD_DRIVE_WIDTH_OFS, 32'h300);
    idle(1);
    check("cfg_width_after_err", 32'(cfg_width), 32'd768);

    // Reset asserted during a write data phase
    op(32'h0000_0000, 1'b1, HSIZE_WORD, 32'h55, 1'b0, 32'd0, 1'b0);
    bus.HSEL = 1'b0;
    bus.HTRANS = HTRANS_IDLE;
    bus.HWDATA = 32'h55;
    #2 HRESETn = 1'b0;
    #1;
    check("midrst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
    check("midrst_hresp", 32'(bus.HRESP), 32'd0);
    check("midrst_cfg_width", 32'(cfg_width), 32'd0);
    repeat (2) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    pend_wdata = '0;
    rd(LCD_DRIVE_WIDTH_OFS, 32'h0);
    idle(1);

`ifdef LCD_REGS_SHADOW_EN
    wr(LCD_DRIVE_WIDTH_OFS, 32'd100);
    wr(LCD_DRIVE_START_OFS, 32'h1);
    idle(2);
    check("shadow_first", 32'(cfg_width), 32'd100);
    wr(LCD_DRIVE_WIDTH_OFS, 32'd200);
    idle(2);
    check("shadow_frozen", 32'(cfg_width), 32'd100);
    rd(LCD_DRIVE_WIDTH_OFS, 32'd200);
    wr(LCD_DRIVE_START_OFS, 32'h1);
    idle(2);
    check("shadow_reload", 32'(cfg_width), 32'd200);
`endif

    idle(3);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_drive_ahb_regs.md
Name: lcd_drive_ahb_regs

Overview:
AHB-Lite slave responder holding the LCD drive configuration and control registers. The riscv_dummy/RISC-V master programs these registers with single word transfers. The block drives static configuration plus a one-cycle start pulse to the LCD drive engine, and reports the engine's busy and frame-done status back to software. It sits on the AHB fabric alongside the ALU and multiplier slaves.

Parameters:
W_ADDR, 32, AHB address width
W_DATA, 32, AHB data width
W_SIZE, 12, width/height field width
W_DELAY, 12, delay field width
W_FRAME_SIZE, 25, data-count field width (2*W_SIZE+1)
IMG_PIX_W, 8, brightness value width

Ports:
HCLK  in  1  system clock
HRESETn  in  1  asynchronous active-low reset
HSEL  in  1  slave select
HADDR  in  W_ADDR  address; bits [11:0] decoded
HTRANS  in  2  transfer type; NONSEQ/SEQ are active
HWRITE  in  1  write = 1
HSIZE  in  3  transfer size
HWDATA  in  W_DATA  write data, valid in the data phase
HREADY  in  1  bus ready
HREADYOUT  out  1  slave ready
HRESP  out  1  0 = OKAY, 1 = ERROR
HRDATA  out  W_DATA  read data
drv_busy  in  1  engine is transmitting a frame
drv_frame_done  in  1  one-cycle pulse at end of frame
cfg_width, cfg_height  out  W_SIZE each  frame geometry
cfg_start_up_delay, cfg_vsync_cycle, cfg_vsync_delay, cfg_hsync_delay, cfg_frame_trans_delay  out  W_DELAY each  timing
cfg_data_count  out  W_FRAME_SIZE  pixel pairs per frame
cfg_br_mode  out  1  brightness mode
cfg_br_value  out  IMG_PIX_W  brightness offset
drv_start  out  1  one-cycle start pulse

Behaviour:
- Register map (byte offsets, all R/W unless noted):
  - 0x00 WIDTH, 0x04 HEIGHT, 0x08 START_UP_DELAY, 0x0C VSYNC_CYCLE
  - 0x10 VSYNC_DELAY, 0x14 HSYNC_DELAY, 0x18 FRAME_TRANS_DELAY, 0x1C DATA_COUNT
  - 0x20 BR_MODE, 0x24 BR_VALUE
  - 0x28 START: write bit0 = 1 issues the pulse; reads as 0
  - 0x2C STATUS: bit0 busy (RO, live drv_busy); bit1 frame_done (sticky, write-1-to-clear); bit2 start_overrun (sticky, W1C)
- Field widths: fields are zero-extended on read. Write data above a field's width is discarded.
- Reset values: all registers 0. HREADYOUT = 1, HRESP = 0, HRDATA = 0, drv_start = 0.
- Address phase: captured when HSEL & HREADY & HTRANS[1]. The block latches offset, write flag and a valid flag.
- Legal transfer: HSIZE = 3'b010, HADDR[1:0] = 0, offset ≤ 0x2C. Anything else is an ERROR transfer.
- Legal write: zero wait state. HWDATA is committed at the clock edge ending the data phase.
- Legal read: zero wait state. HRDATA is driven combinationally in the data phase from the latched offset. A read directly following a write to the same register returns the new value.
- HRDATA is 0 when not in a read data phase.
- ERROR response, two cycles:
  - cycle 1: HREADYOUT = 0, HRESP = 1
  - cycle 2: HREADYOUT = 1, HRESP = 1
  - No register changes.
  - A new address phase during cycle 1 is ignored (HREADY is low).
- IDLE/BUSY transfers, or HSEL low: OKAY, no effect.
- START write of 1:
  - drv_busy = 0: drv_start = 1 for exactly the cycle after commit.
  - drv_busy = 1: no pulse; start_overrun is set.
  - Writing 0 has no effect.
- drv_frame_done pulse sets frame_done.
  - Simultaneous set and W1C: set wins.
  - Same rule applies to start_overrun.
- Reset mid-transfer: outputs return to reset values immediately. The pending data phase is discarded.

Optional Feature:
LCD_REGS_SHADOW_EN:
- Defined: the cfg_* outputs come from shadow registers. Shadows copy the programmed values on each drv_start pulse, so configuration is frozen while a frame is in flight. Readback still returns the programmed values.
- Undefined: cfg_* outputs are driven directly by the programmed registers.

Decomposition:
- Shared package `lcd_drive_pkg`:
  - register offset constants (LCD_DRIVE_*_OFS)
  - HTRANS/HRESP/HSIZE encodings
  - STATUS bit indices
  - width parameters
- Sub-module `ahb_slave_if`: address-phase capture plus the OKAY/ERROR response FSM (states IDLE, DATA, ERR1, ERR2). It exposes wr_en, rd_en, offset and wdata to the register bank.

Test Plan:
- Write 768 to 0x00 and 512 to 0x04, then read both back-to-back -> HRDATA = 0x300 and 0x200, HRESP OKAY, zero wait states; cfg_width = 768.
- Write 0xFFFF_FFFF to 0x24 -> readback 0x0000_00FF, cfg_br_value = 0xFF.
- Write 1 to 0x28 with drv_busy = 0 -> drv_start high exactly one cycle. Repeat with drv_busy = 1 -> no pulse, STATUS = 0x5.
- Pulse drv_frame_done -> STATUS bit1 = 1. Write 0x2 to 0x2C in the same cycle as another frame_done pulse -> bit1 stays 1. Clear alone -> 0.
- Read 0x30 and perform a halfword write to 0x00 -> two-cycle ERROR each (HREADYOUT 0 then 1, HRESP 1), registers unchanged.
- Assert HRESETn low during a write data phase -> register keeps 0, HREADYOUT = 1. With LCD_REGS_SHADOW_EN: change WIDTH after start -> cfg_width unchanged until the next drv_start.
